// File: rtl/mci_mcu_sram_zeroize.sv
// rtl/mci_mcu_sram_zeroize.sv - MCU SRAM zeroize/init sweep with controller pass-through
module mci_mcu_sram_zeroize #(
  parameter int MCU_SRAM_SIZE_KB = 1024,
  parameter int DATA_W           = 32,
  parameter int ECC_W            = 7,
  parameter int AUTO_INIT        = 1,
  localparam int DEPTH           = MCU_SRAM_SIZE_KB * 8192 / DATA_W,
  localparam int ADDR_W          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zeroize_req,
  input  logic              up_cs,
  input  logic              up_we,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_wdata,
  input  logic [ECC_W-1:0]  up_wecc,
  output logic [DATA_W-1:0] up_rdata,
  output logic [ECC_W-1:0]  up_recc,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [ECC_W-1:0]  sram_wecc,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic [ECC_W-1:0]  sram_recc,
  output logic              busy,
  output logic              init_done,
  output logic              blocked_err,
  output logic [7:0]        blocked_cnt
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              blocked_err_q;
  logic [7:0]        blocked_cnt_q;
  logic              busy_w;
  logic              blocked;

  // Busy covers the sweep and its closing DONE cycle; reset forces it low.
  assign busy_w  = !rst && (state_q == SWEEP || state_q == DONE);
  assign blocked = busy_w && up_cs;

  // State, sweep address and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= (AUTO_INIT != 0) ? SWEEP : IDLE;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      blocked_err_q <= 1'b0;
      blocked_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      if (blocked) begin
        blocked_err_q <= 1'b1;
        if (blocked_cnt_q != 8'hFF) begin
          blocked_cnt_q <= blocked_cnt_q + 8'd1;
        end
      end
    end
  end

  // Next-state logic: a zeroize request always (re)starts the sweep at address 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      IDLE: begin
        if (zeroize_req) begin
          state_d     = SWEEP;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end
      end
      SWEEP: begin
        if (zeroize_req) begin
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (zeroize_req) begin
          state_d     = SWEEP;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM port mux: zero writes while sweeping, nothing in DONE or reset, else pass-through.
  always_comb begin
    sram_cs    = up_cs;
    sram_we    = up_we;
    sram_addr  = up_addr;
    sram_wdata = up_wdata;
    sram_wecc  = up_wecc;
    if (rst) begin
      sram_cs = 1'b0;
      sram_we = 1'b0;
    end else if (state_q == SWEEP) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = cnt_q;
      sram_wdata = '0;
      sram_wecc  = '0;
    end else if (state_q == DONE) begin
      sram_cs = 1'b0;
      sram_we = 1'b0;
    end
  end

  assign up_rdata    = sram_rdata;
  assign up_recc     = sram_recc;
  assign busy        = busy_w;
  assign init_done   = init_done_q;
  assign blocked_err = blocked_err_q;
  assign blocked_cnt = blocked_cnt_q;

endmodule

// File: tb/tb_mci_mcu_sram_zeroize.sv
// tb/tb_mci_mcu_sram_zeroize.sv - directed bench for mci_mcu_sram_zeroize
module tb_mci_mcu_sram_zeroize;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Auto-init instance, 256 words
  logic        zeroize_req, up_cs, up_we;
  logic [7:0]  up_addr;
  logic [31:0] up_wdata, up_rdata, sram_wdata, sram_rdata;
  logic [6:0]  up_wecc, up_recc, sram_wecc, sram_recc;
  logic        sram_cs, sram_we, busy, init_done, blocked_err;
  logic [7:0]  sram_addr, blocked_cnt;

  // Idle-after-reset instance
  logic        z0_req, u0_cs, u0_we;
  logic [7:0]  u0_addr, s0_addr, b0_cnt;
  logic [31:0] u0_wdata, u0_rdata, s0_wdata, s0_rdata;
  logic [6:0]  u0_wecc, u0_recc, s0_wecc, s0_recc;
  logic        s0_cs, s0_we, b0_busy, b0_done, b0_err;

  int tests = 0;
  int fails = 0;

  mci_mcu_sram_zeroize #(.MCU_SRAM_SIZE_KB(1), .DATA_W(32), .ECC_W(7), .AUTO_INIT(1)) dut (
    .clk(clk), .rst(rst), .zeroize_req(zeroize_req),
    .up_cs(up_cs), .up_we(up_we), .up_addr(up_addr), .up_wdata(up_wdata), .up_wecc(up_wecc),
    .up_rdata(up_rdata), .up_recc(up_recc),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wecc(sram_wecc), .sram_rdata(sram_rdata), .sram_recc(sram_recc),
    .busy(busy), .init_done(init_done), .blocked_err(blocked_err), .blocked_cnt(blocked_cnt)
  );

  mci_mcu_sram_zeroize #(.MCU_SRAM_SIZE_KB(1), .DATA_W(32), .ECC_W(7), .AUTO_INIT(0)) dut0 (
    .clk(clk), .rst(rst), .zeroize_req(z0_req),
    .up_cs(u0_cs), .up_we(u0_we), .up_addr(u0_addr), .up_wdata(u0_wdata), .up_wecc(u0_wecc),
    .up_rdata(u0_rdata), .up_recc(u0_recc),
    .sram_cs(s0_cs), .sram_we(s0_we), .sram_addr(s0_addr), .sram_wdata(s0_wdata),
    .sram_wecc(s0_wecc), .sram_rdata(s0_rdata), .sram_recc(s0_recc),
    .busy(b0_busy), .init_done(b0_done), .blocked_err(b0_err), .blocked_cnt(b0_cnt)
  );

  // Behavioural SRAM macro with one-cycle read latency
  logic [38:0] mem [256];
  logic [38:0] rd_q;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= {sram_wecc, sram_wdata};
      else         rd_q <= mem[sram_addr];
    end
  end
  assign sram_rdata = rd_q[31:0];
  assign sram_recc  = rd_q[38:32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; zeroize_req = 1'b0; up_cs = 1'b0; up_we = 1'b0;
    up_addr = 8'h0; up_wdata = 32'h0; up_wecc = 7'h0;
    z0_req = 1'b0; u0_cs = 1'b0; u0_we = 1'b0; u0_addr = 8'h0;
    u0_wdata = 32'h0; u0_wecc = 7'h0; s0_rdata = 32'h0; s0_recc = 7'h0;

    // Reset state
    #1;
    check("rst_sram_cs", sram_cs, 0);
    step();
    step();
    check("rst_sram_cs2", sram_cs, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_blocked_err", blocked_err, 0);
    check("rst_blocked_cnt", blocked_cnt, 0);
    rst = 1'b0;

    // AUTO_INIT=0 instance: idle, immediate pass-through
    u0_cs = 1'b1; u0_we = 1'b1; u0_addr = 8'h33; u0_wdata = 32'hCAFE0001; u0_wecc = 7'h15;
    s0_rdata = 32'hA5A50001; s0_recc = 7'h4C;
    #1;
    check("ai0_busy", b0_busy, 0);
    check("ai0_init_done", b0_done, 0);
    check("ai0_pass", {s0_cs, s0_we, s0_addr, s0_wdata, s0_wecc}, {1'b1, 1'b1, 8'h33, 32'hCAFE0001, 7'h15});
    check("ai0_rdata", {u0_rdata, u0_recc}, {32'hA5A50001, 7'h4C});

    // Initial sweep: 256 zero writes then DONE
    for (int i = 0; i < 256; i++) begin
      check($sformatf("sweep1_%0d", i), {busy, sram_cs, sram_we, sram_addr, sram_wdata, sram_wecc},
            {1'b1, 1'b1, 1'b1, 8'(i), 32'h0, 7'h0});
      step();
    end
    u0_cs = 1'b0;
    check("ai0_still_idle", {b0_busy, b0_err}, 0);
    check("done1_busy", busy, 1);
    check("done1_sram_cs", sram_cs, 0);
    check("done1_init_done", init_done, 0);
    step();
    check("idle1_busy", busy, 0);
    check("idle1_init_done", init_done, 1);
    check("mem_0", mem[0], 0);
    check("mem_255", mem[255], 0);

    // Pass-through write then read
    up_cs = 1'b1; up_we = 1'b1; up_addr = 8'h10; up_wdata = 32'hDEADBEEF; up_wecc = 7'h2A;
    #1;
    check("pt_write", {sram_cs, sram_we, sram_addr, sram_wdata, sram_wecc},
          {1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 7'h2A});
    step();
    up_we = 1'b0;
    #1;
    check("pt_read_req", {sram_cs, sram_we, sram_addr}, {1'b1, 1'b0, 8'h10});
    step();
    up_cs = 1'b0;
    #1;
    check("pt_rdata", up_rdata, 32'hDEADBEEF);
    check("pt_recc", up_recc, 7'h2A);
    check("pt_no_block", {blocked_err, blocked_cnt}, 0);

    // Zeroize with controller traffic, re-pulsed at address 100
    zeroize_req = 1'b1;
    step();
    zeroize_req = 1'b0;
    check("z_busy", busy, 1);
    check("z_init_cleared", init_done, 0);
    up_cs = 1'b1; up_we = 1'b1; up_addr = 8'h10; up_wdata = 32'h12345678; up_wecc = 7'h11;
    for (int i = 0; i <= 100; i++) begin
      zeroize_req = (i == 100);
      #1;
      if (i == 10) check("cnt_10", blocked_cnt, 10);
      check($sformatf("sweep2_%0d", i), {init_done, sram_cs, sram_we, sram_addr, sram_wdata, sram_wecc},
            {1'b0, 1'b1, 1'b1, 8'(i), 32'h0, 7'h0});
      step();
    end
    zeroize_req = 1'b0;
    for (int j = 0; j < 256; j++) begin
      check($sformatf("sweep3_%0d", j), {init_done, busy, sram_cs, sram_we, sram_addr, sram_wdata},
            {1'b0, 1'b1, 1'b1, 1'b1, 8'(j), 32'h0});
      step();
    end
    check("done2_blocked", {busy, sram_cs, init_done}, {1'b1, 1'b0, 1'b0});
    step();
    up_cs = 1'b0;
    #1;
    check("idle2_init_done", {busy, init_done}, {1'b0, 1'b1});
    check("blocked_err", blocked_err, 1);
    check("blocked_sat", blocked_cnt, 8'd255);
    up_cs = 1'b1; up_we = 1'b0; up_addr = 8'h10;
    step();
    up_cs = 1'b0;
    #1;
    check("zero_rdata", {up_rdata, up_recc}, 0);

    // Reset in the middle of a sweep
    zeroize_req = 1'b1;
    step();
    zeroize_req = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("mid_addr_50", {sram_cs, sram_addr}, {1'b1, 8'd50});
    rst = 1'b1;
    #1;
    check("mid_rst_cs", {sram_cs, sram_we, busy}, 0);
    step();
    rst = 1'b0;
    #1;
    check("restart_addr0", {busy, sram_cs, sram_we, sram_addr}, {1'b1, 1'b1, 1'b1, 8'd0});
    check("restart_cleared", {blocked_err, blocked_cnt, init_done}, 0);
    for (int i = 0; i < 257; i++) step();
    check("restart_done", {busy, init_done}, {1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mci_mcu_sram_zeroize.md
# mci_mcu_sram_zeroize

Zeroization and initialization stage between the MCU SRAM controller's SRAM request port and the physical MCU SRAM macro. After reset, and on any later zeroize request, it sweeps every SRAM word with zero data and zero ECC while holding off controller traffic. When idle it passes controller requests straight through to the macro. It reports completion and any traffic it had to discard.

## Interface
Parameters:
- MCU_SRAM_SIZE_KB, 1024: SRAM capacity in KiB.
- DATA_W, 32: data width per word.
- ECC_W, 7: ECC width per word.
- AUTO_INIT, 1: when 1, a sweep starts automatically after reset; when 0, the block is idle after reset.
- DEPTH (derived): MCU_SRAM_SIZE_KB*8192/DATA_W words.
- ADDR_W (derived): $clog2(DEPTH).

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- zeroize_req  in  1  single-cycle pulse that starts a full sweep.
- up_cs  in  1  controller chip select.
- up_we  in  1  controller write enable.
- up_addr  in  ADDR_W  controller word address.
- up_wdata  in  DATA_W  controller write data.
- up_wecc  in  ECC_W  controller write ECC.
- up_rdata  out  DATA_W  read data returned to the controller.
- up_recc  out  ECC_W  read ECC returned to the controller.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_wecc  out  ECC_W  SRAM write ECC.
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read.
- sram_recc  in  ECC_W  SRAM read ECC, valid 1 cycle after a read.
- busy  out  1  high while a sweep is in progress.
- init_done  out  1  sticky; set when a sweep completes.
- blocked_err  out  1  sticky; set when a controller request arrives during a sweep.
- blocked_cnt  out  8  saturating count of dropped controller requests.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- On rst:
  - next state is SWEEP if AUTO_INIT=1, otherwise IDLE.
  - Address counter, blocked_err, blocked_cnt and init_done all clear to 0.
- SWEEP:
  - Each cycle drives sram_cs=1, sram_we=1, sram_addr=counter, sram_wdata=0, sram_wecc=0.
  - The counter increments by 1 each cycle.
  - After the write to address DEPTH-1: go to DONE and reset the counter to 0. The counter never wraps past DEPTH-1.
- DONE: lasts one cycle. Sets init_done, then goes to IDLE.
- IDLE (pass-through):
  - sram_* = up_* combinationally.
  - up_rdata/up_recc = sram_rdata/sram_recc combinationally, at all times.
- zeroize_req:
  - In IDLE or DONE: enters SWEEP next cycle and clears init_done in that same transition.
  - In SWEEP: restarts the counter at 0. The sweep re-runs in full, and init_done stays 0.
- up_cs=1 while busy:
  - The request is not forwarded to the SRAM.
  - blocked_err is set.
  - blocked_cnt increments and saturates at 255.
- A request in the same cycle the FSM enters SWEEP is blocked. A request in the DONE cycle is also blocked; pass-through resumes in IDLE.
- blocked_err and blocked_cnt clear only on rst.
- Reset mid-sweep: the sweep is abandoned. With AUTO_INIT=1 a fresh sweep restarts from address 0.
- Outputs driven while busy: up_rdata/up_recc show whatever is on the SRAM read bus and carry no meaning.

## Timing
- busy = (state==SWEEP) or (state==DONE), decoded from registered state.
- Pass-through adds zero cycles of latency; the SRAM's own 1-cycle read latency is unchanged.
- Sweep length: exactly DEPTH write cycles, plus 1 DONE cycle.
- First sweep write happens in the first cycle after rst deasserts (AUTO_INIT=1).
- init_done rises in the cycle after DONE, i.e. DEPTH+1 cycles after the sweep starts.
- zeroize_req sampled in cycle N: busy=1 and the first zero write both occur in cycle N+1.
- Reset values of outputs: sram_cs=0 and sram_we=0 during rst. All other outputs 0 except pass-through outputs, which follow the up_* and sram_* inputs.

## Test plan
1. MCU_SRAM_SIZE_KB=1 (DEPTH=256), AUTO_INIT=1, release rst -> addresses 0..255 each written once with data 0 and ECC 0 on consecutive cycles. busy is high for 257 cycles, then init_done=1.
2. After init, write 0xDEADBEEF with ECC 0x2A at address 0x10, then read it back -> SRAM sees the write in the same cycle; up_rdata=0xDEADBEEF and up_recc=0x2A one cycle after the read.
3. Pulse zeroize_req, then issue 300 controller requests during the sweep -> none reach the SRAM; blocked_err=1, blocked_cnt=255 (saturated); a read of 0x10 afterwards returns 0.
4. Pulse zeroize_req a second time at sweep address 100 -> the counter restarts at 0; the sweep ends 256 writes after the second pulse; init_done stays 0 until then.
5. Assert rst at sweep address 50 -> sram_cs=0 during reset; a new sweep starts at address 0; blocked_err and blocked_cnt are cleared.
6. AUTO_INIT=0, release rst -> busy=0 and init_done=0, and requests pass through immediately.
